// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: state/column widths, the inv-mix FSM state type and
// GF(2^8) multiply helpers built from xtime chains (no lookup tables).
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_COL_W   = 32;

  typedef enum logic [1:0] {
    StIdle,
    StMix,
    StDone
  } inv_mix_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_addkey_mixcol_if.sv
// Input/output handshake bundle for inv_addkey_mixcol.
// last_round exists only when INV_MIX_LAST_ROUND_EN is defined.
interface inv_addkey_mixcol_if;
  import aes_pkg::*;

  logic [AES_STATE_W-1:0] state_in;
  logic [AES_STATE_W-1:0] round_key;
`ifdef INV_MIX_LAST_ROUND_EN
  logic                   last_round;
`endif
  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] state_out;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
`ifdef INV_MIX_LAST_ROUND_EN
    output last_round,
`endif
    output state_in,
    output round_key,
    output in_valid,
    input  in_ready,
    input  state_out,
    input  out_valid,
    output out_ready
  );

  modport slave (
`ifdef INV_MIX_LAST_ROUND_EN
    input  last_round,
`endif
    input  state_in,
    input  round_key,
    input  in_valid,
    output in_ready,
    output state_out,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column; row 0 is the most significant byte.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] column,
  output logic [AES_COL_W-1:0] mixed
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = column[31:24];
  assign a1 = column[23:16];
  assign a2 = column[15:8];
  assign a3 = column[7:0];

  // Multiplier row {0e,0b,0d,09} rotated right one byte per output row
  assign b0 = gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3);
  assign b1 = gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3);
  assign b2 = gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3);
  assign b3 = gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3);

  assign mixed = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_addkey_mixcol.sv
// AddRoundKey followed by column-serial InvMixColumns for one decryption round.
// Define INV_MIX_LAST_ROUND_EN to add the last_round bypass of InvMixColumns.
module inv_addkey_mixcol
  import aes_pkg::*;
#(
  parameter int unsigned NCOL = 4  // only 4 (AES-128) is meaningful
) (
  input  logic              clk,
  input  logic              reset,
  inv_addkey_mixcol_if.slave bus
);

  localparam int unsigned ColW = $clog2(NCOL);

  inv_mix_state_e         state_q, state_d;
  logic [AES_STATE_W-1:0] st_q, st_d;
  logic [ColW-1:0]        col_q, col_d;
  logic [AES_COL_W-1:0]   mix_in, mix_out;
  logic                   skip_mix;

`ifdef INV_MIX_LAST_ROUND_EN
  assign skip_mix = bus.last_round;
`else
  assign skip_mix = 1'b0;
`endif

  // Single shared column datapath, selected by col_q
  always_comb begin
    mix_in = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      if (col_q == ColW'(c)) begin
        mix_in = st_q[AES_STATE_W - AES_COL_W * (c + 1) +: AES_COL_W];
      end
    end
  end

  inv_mix_column u_inv_mix_column (
    .column (mix_in),
    .mixed  (mix_out)
  );

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    col_d   = col_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          st_d    = bus.state_in ^ bus.round_key;
          col_d   = '0;
          state_d = skip_mix ? StDone : StMix;
        end
      end
      StMix: begin
        for (int unsigned c = 0; c < NCOL; c++) begin
          if (col_q == ColW'(c)) begin
            st_d[AES_STATE_W - AES_COL_W * (c + 1) +: AES_COL_W] = mix_out;
          end
        end
        col_d = col_q + ColW'(1);
        if (col_q == ColW'(NCOL - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      st_q    <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      col_q   <= col_d;
    end
  end

  // Gated by reset so nothing is offered as accepted while the block is held in reset
  assign bus.in_ready  = (state_q == StIdle) && !reset;
  assign bus.out_valid = (state_q == StDone);
  assign bus.state_out = st_q;

endmodule
